// File: rtl/riscv_memreq_queue_if.sv
// riscv_memreq_queue_if
// Bundles the two handshakes around the memory request queue:
//   upstream   : req_i + payload (adr/size/lock/we/cm_*/pagefault) in, stall_o back
//   downstream : req_o + head payload out, ack_i back, pagefault_o fault report
//   control    : flush_i in, empty_o out
// Modports:
//   slave  - the queue itself
//   master - the environment (translation stage + memory front-end)
interface riscv_memreq_queue_if #(
    parameter int PLEN = 34
);
    // Access size encoding shared by both sides.
    typedef logic [2:0] biu_size_t;

    logic              flush_i;
    logic              req_i;
    logic [PLEN-1:0]   adr_i;
    biu_size_t         size_i;
    logic              lock_i;
    logic              we_i;
    logic              cm_clean_i;
    logic              cm_invalidate_i;
    logic              pagefault_i;
    logic              stall_o;

    logic              req_o;
    logic [PLEN-1:0]   adr_o;
    biu_size_t         size_o;
    logic              lock_o;
    logic              we_o;
    logic              cm_clean_o;
    logic              cm_invalidate_o;
    logic              ack_i;
    logic              pagefault_o;
    logic              empty_o;

    modport slave (
        input  flush_i, req_i, adr_i, size_i, lock_i, we_i,
               cm_clean_i, cm_invalidate_i, pagefault_i, ack_i,
        output stall_o, req_o, adr_o, size_o, lock_o, we_o,
               cm_clean_o, cm_invalidate_o, pagefault_o, empty_o
    );

    modport master (
        output flush_i, req_i, adr_i, size_i, lock_i, we_i,
               cm_clean_i, cm_invalidate_i, pagefault_i, ack_i,
        input  stall_o, req_o, adr_o, size_o, lock_o, we_o,
               cm_clean_o, cm_invalidate_o, pagefault_o, empty_o
    );
endinterface

// File: rtl/riscv_memreq_queue.sv
// riscv_memreq_queue
// DEPTH-entry FIFO of translated physical requests between the MMU stage and
// the cache front-end. The head entry is shown combinationally on the
// downstream side; faulted entries are retired with a one-cycle pagefault_o
// pulse instead of being issued.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset
//   bus    - riscv_memreq_queue_if.slave (upstream, downstream, flush/empty)
module riscv_memreq_queue #(
    parameter int PLEN  = 34,
    parameter int DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    riscv_memreq_queue_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [PLEN-1:0] adr;
        logic [2:0]      size;
        logic            lock;
        logic            we;
        logic            cm_clean;
        logic            cm_inv;
        logic            pf;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          head;
    entry_t          wr_entry;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            inflight_q, inflight_d;
    logic            empty, full, req, push, ack_pop, pf_pop, pop;

    assign head    = mem_q[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign req     = !empty && !head.pf;
    assign ack_pop = req && bus.ack_i;
    // A faulted head seen during flush is simply thrown away with the rest.
    assign pf_pop  = !empty && head.pf && !bus.flush_i;
    assign pop     = ack_pop || pf_pop;
    // Full blocks pushes even when a pop frees a slot in the same cycle.
    assign push    = bus.req_i && !full && !bus.flush_i;

    assign wr_entry = '{adr: bus.adr_i, size: bus.size_i, lock: bus.lock_i,
                        we: bus.we_i, cm_clean: bus.cm_clean_i,
                        cm_inv: bus.cm_invalidate_i, pf: bus.pagefault_i};

    always_comb begin
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        wr_ptr_d   = wr_ptr_q + AW'(push);
        count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
        inflight_d = req && !bus.ack_i;
        if (bus.flush_i) begin
            if (inflight_q && !bus.ack_i) begin
                // Memory already sees the head: keep it alone until acked.
                count_d  = (AW+1)'(1);
                wr_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                // Anything acked this cycle has already advanced rd_ptr_d.
                count_d    = '0;
                wr_ptr_d   = rd_ptr_d;
                inflight_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
        end
    end

    // Payload storage is not reset; it is only meaningful while counted.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign bus.stall_o         = full;
    assign bus.empty_o         = empty;
    assign bus.req_o           = req;
    assign bus.pagefault_o     = pf_pop;
    assign bus.adr_o           = head.adr;
    assign bus.size_o          = head.size;
    assign bus.lock_o          = head.lock;
    assign bus.we_o            = head.we;
    assign bus.cm_clean_o      = head.cm_clean;
    assign bus.cm_invalidate_o = head.cm_inv;
endmodule

// File: tb/tb_riscv_memreq_queue.sv
// tb_riscv_memreq_queue
// Directed stimulus for riscv_memreq_queue. Stimulus pushes the expected
// issue/fault stream into a scoreboard queue; an independent monitor pops and
// compares on every downstream handshake or fault pulse.
module tb_riscv_memreq_queue;
    localparam int PLEN  = 34;
    localparam int DEPTH = 4;
    localparam logic [2:0] SZ_BYTE = 3'd0;
    localparam logic [2:0] SZ_HALF = 3'd1;
    localparam logic [2:0] SZ_WORD = 3'd2;

    typedef struct {
        logic [PLEN-1:0] adr;
        logic [2:0]      size;
        logic            we;
        logic            lock;
        logic            cln;
        logic            inv;
        logic            pf;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb [$];

    riscv_memreq_queue_if #(.PLEN(PLEN)) bus ();

    riscv_memreq_queue #(.PLEN(PLEN), .DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [PLEN-1:0] a, input logic [2:0] sz,
                         input logic we, input logic lk, input logic cl,
                         input logic iv, input logic pf, input bit enq);
        exp_t e;
        bus.req_i           = 1'b1;
        bus.adr_i           = a;
        bus.size_i          = sz;
        bus.we_i            = we;
        bus.lock_i          = lk;
        bus.cm_clean_i      = cl;
        bus.cm_invalidate_i = iv;
        bus.pagefault_i     = pf;
        if (enq) begin
            e = '{adr: a, size: sz, we: we, lock: lk, cln: cl, inv: iv, pf: pf};
            sb.push_back(e);
        end
    endtask

    task automatic idle_in();
        bus.req_i           = 1'b0;
        bus.pagefault_i     = 1'b0;
        bus.lock_i          = 1'b0;
        bus.cm_clean_i      = 1'b0;
        bus.cm_invalidate_i = 1'b0;
    endtask

    task automatic drain(input string nm);
        bit done;
        done = 1'b0;
        bus.ack_i = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(posedge clk); #1;
            if (bus.empty_o) done = 1'b1;
        end
        chk({nm, "_drained"}, 64'(done), 64'd1);
        bus.ack_i = 1'b0;
        chk({nm, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    // Monitor: every issue (req_o && ack_i) or fault pulse consumes one entry.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            chk("req_pf_exclusive", 64'(bus.req_o & bus.pagefault_o), 64'd0);
            if ((bus.req_o && bus.ack_i) || bus.pagefault_o) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_output: adr 0x%0h req %0b pf %0b with empty scoreboard",
                             bus.adr_o, bus.req_o, bus.pagefault_o);
                end else begin
                    e = sb.pop_front();
                    chk("head_adr", 64'(bus.adr_o), 64'(e.adr));
                    chk("head_fault", 64'(bus.pagefault_o), 64'(e.pf));
                    if (bus.req_o) begin
                        chk("head_size",  64'(bus.size_o), 64'(e.size));
                        chk("head_we",    64'(bus.we_o), 64'(e.we));
                        chk("head_lock",  64'(bus.lock_o), 64'(e.lock));
                        chk("head_clean", 64'(bus.cm_clean_o), 64'(e.cln));
                        chk("head_inv",   64'(bus.cm_invalidate_o), 64'(e.inv));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        bus.flush_i = 1'b0;
        bus.ack_i   = 1'b0;
        bus.adr_i   = '0;
        bus.size_i  = SZ_BYTE;
        bus.we_i    = 1'b0;
        idle_in();
        #1;
        chk("rst_req",   64'(bus.req_o), 64'd0);
        chk("rst_pf",    64'(bus.pagefault_o), 64'd0);
        chk("rst_stall", 64'(bus.stall_o), 64'd0);
        chk("rst_empty", 64'(bus.empty_o), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single request with ack tied high.
        bus.ack_i = 1'b1;
        @(posedge clk); #1;
        drive(34'h1_0000_1000, SZ_WORD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        idle_in();
        chk("single_req",  64'(bus.req_o), 64'd1);
        chk("single_adr",  64'(bus.adr_o), 64'h1_0000_1000);
        chk("single_size", 64'(bus.size_o), 64'(SZ_WORD));
        @(posedge clk); #1;
        chk("single_empty", 64'(bus.empty_o), 64'd1);
        chk("single_req_done", 64'(bus.req_o), 64'd0);
        bus.ack_i = 1'b0;

        // Fill to DEPTH, hold the fifth upstream, release with one ack.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            drive(34'h100 + 34'(4 * i), SZ_HALF, 1'(i & 1), 1'(i == 1), 1'(i == 2), 1'(i == 3), 1'b0, 1'b1);
        end
        @(posedge clk); #1;
        drive(34'h110, SZ_WORD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fill_stall", 64'(bus.stall_o), 64'd1);
        chk("fill_head_adr", 64'(bus.adr_o), 64'h100);
        @(posedge clk); #1;
        chk("fill_stall_hold", 64'(bus.stall_o), 64'd1);
        chk("fill_req_hold", 64'(bus.req_o), 64'd1);
        bus.ack_i = 1'b1;
        @(posedge clk); #1;
        bus.ack_i = 1'b0;
        chk("fill_stall_release", 64'(bus.stall_o), 64'd0);
        drive(34'h110, SZ_WORD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        idle_in();
        chk("fill_stall_again", 64'(bus.stall_o), 64'd1);
        drain("fill");

        // Back-to-back stream wrapping the pointers.
        bus.ack_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i > 0) begin
                chk("wrap_req_cont", 64'(bus.req_o), 64'd1);
                chk("wrap_no_stall", 64'(bus.stall_o), 64'd0);
            end
            drive(34'h200 + 34'(4 * i), SZ_BYTE, 1'(i & 1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        @(posedge clk); #1;
        idle_in();
        chk("wrap_req_last", 64'(bus.req_o), 64'd1);
        @(posedge clk); #1;
        chk("wrap_empty", 64'(bus.empty_o), 64'd1);
        chk("wrap_req_off", 64'(bus.req_o), 64'd0);

        // A ok, B faulted, C ok.
        @(posedge clk); #1;
        drive(34'h300, SZ_WORD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(34'h304, SZ_WORD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("pf_a_adr", 64'(bus.adr_o), 64'h300);
        @(posedge clk); #1;
        drive(34'h308, SZ_WORD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("pf_b_pulse", 64'(bus.pagefault_o), 64'd1);
        chk("pf_b_noreq", 64'(bus.req_o), 64'd0);
        @(posedge clk); #1;
        idle_in();
        chk("pf_b_once", 64'(bus.pagefault_o), 64'd0);
        chk("pf_c_req", 64'(bus.req_o), 64'd1);
        chk("pf_c_adr", 64'(bus.adr_o), 64'h308);
        @(posedge clk); #1;
        chk("pf_empty", 64'(bus.empty_o), 64'd1);
        bus.ack_i = 1'b0;

        // Flush with the head in flight: only the head survives.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive(34'h400 + 34'(4 * i), SZ_WORD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        @(posedge clk); #1;
        idle_in();
        chk("fl_head_adr", 64'(bus.adr_o), 64'h400);
        @(posedge clk); #1;
        bus.flush_i = 1'b1;
        drive(34'h4F0, SZ_BYTE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        while (sb.size() > 1) void'(sb.pop_back());
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        idle_in();
        chk("fl_keep_req", 64'(bus.req_o), 64'd1);
        chk("fl_keep_adr", 64'(bus.adr_o), 64'h400);
        chk("fl_keep_notempty", 64'(bus.empty_o), 64'd0);
        bus.ack_i = 1'b1;
        @(posedge clk); #1;
        bus.ack_i = 1'b0;
        chk("fl_after_ack_empty", 64'(bus.empty_o), 64'd1);
        chk("fl_after_ack_req", 64'(bus.req_o), 64'd0);
        @(posedge clk); #1;
        chk("fl_no_more_req", 64'(bus.req_o), 64'd0);

        // Flush with two entries while the head is acked in the same cycle.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            drive(34'h500 + 34'(4 * i), SZ_HALF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        @(posedge clk); #1;
        idle_in();
        @(posedge clk); #1;
        bus.flush_i = 1'b1;
        bus.ack_i   = 1'b1;
        while (sb.size() > 1) void'(sb.pop_back());
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        bus.ack_i   = 1'b0;
        chk("fl2_empty", 64'(bus.empty_o), 64'd1);
        chk("fl2_req", 64'(bus.req_o), 64'd0);

        // Asynchronous reset while full.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            drive(34'h600 + 34'(4 * i), SZ_WORD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        @(posedge clk); #1;
        idle_in();
        chk("ar_full", 64'(bus.stall_o), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_req", 64'(bus.req_o), 64'd0);
        chk("ar_stall", 64'(bus.stall_o), 64'd0);
        chk("ar_empty", 64'(bus.empty_o), 64'd1);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ar_post_empty", 64'(bus.empty_o), 64'd1);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
